// File: rtl/cpu_bus_pkg.sv
// Shared SRAM-like bus definitions: requester IDs, access-size encodings and
// the grant-lock state type used by the memory-port arbiter.
package cpu_bus_pkg;

    localparam logic REQ_INST = 1'b0;
    localparam logic REQ_DATA = 1'b1;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    typedef enum logic [1:0] {
        LOCK_IDLE = 2'd0,
        LOCK_INST = 2'd1,
        LOCK_DATA = 2'd2
    } lock_state_t;

endpackage

// File: rtl/sram_like_arbiter_id_fifo.sv
// In-order FIFO of 1-bit requester IDs; pointers carry an extra wrap bit so
// full and empty are distinguished without a separate counter.
module id_fifo #(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic clk,
    input  logic resetn,
    input  logic push,
    input  logic push_id,
    input  logic pop,
    output logic full,
    output logic empty,
    output logic head
);

    logic [DEPTH-1:0] slots;
    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign head  = slots[rd_ptr[PTR_W-1:0]];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Payload needs no reset: it is only read while the FIFO is non-empty.
    always_ff @(posedge clk) begin
        if (push) slots[wr_ptr[PTR_W-1:0]] <= push_id;
    end

endmodule

// File: rtl/sram_like_arbiter.sv
// Shares one SRAM-like port between instruction fetch and data access, with
// data given fixed priority and responses steered back in acceptance order.
module sram_like_arbiter
    import cpu_bus_pkg::*;
#(
    parameter int OUTSTANDING = 4,
    parameter int PTR_W       = $clog2(OUTSTANDING)
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [3:0]  inst_wstrb,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata,
    output logic        protocol_err
);

    lock_state_t lock_state, lock_next;
    logic owner_valid, owner_id, owner_req, sel_data;
    logic accept, pop, fifo_full, fifo_empty, fifo_head;

    always_comb begin
        owner_valid = 1'b0;
        owner_id    = REQ_INST;
        if (lock_state == LOCK_INST) begin
            owner_valid = 1'b1;
            owner_id    = REQ_INST;
        end else if (lock_state == LOCK_DATA) begin
            owner_valid = 1'b1;
            owner_id    = REQ_DATA;
        end else if (data_req) begin
            owner_valid = 1'b1;
            owner_id    = REQ_DATA;
        end else if (inst_req) begin
            owner_valid = 1'b1;
            owner_id    = REQ_INST;
        end
    end

    assign sel_data  = owner_valid && (owner_id == REQ_DATA);
    assign owner_req = owner_valid && (sel_data ? data_req : inst_req);

    // resetn gates the request combinationally so nothing leaks out during reset.
    assign mem_req   = owner_req && !fifo_full && resetn;
    assign accept    = mem_req && mem_addr_ok;
    assign mem_wr    = sel_data ? data_wr    : inst_wr;
    assign mem_size  = sel_data ? data_size  : inst_size;
    assign mem_wstrb = sel_data ? data_wstrb : inst_wstrb;
    assign mem_addr  = sel_data ? data_addr  : inst_addr;
    assign mem_wdata = sel_data ? data_wdata : inst_wdata;

    assign data_addr_ok = accept && sel_data;
    assign inst_addr_ok = accept && !sel_data;

    assign pop          = mem_data_ok && !fifo_empty;
    assign data_data_ok = pop && (fifo_head == REQ_DATA);
    assign inst_data_ok = pop && (fifo_head == REQ_INST);
    assign inst_rdata   = mem_rdata;
    assign data_rdata   = mem_rdata;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) lock_state <= LOCK_IDLE;
        else         lock_state <= lock_next;
    end

    // A stalled handshake pins the owner; a withdrawn request releases it.
    always_comb begin
        lock_next = lock_state;
        if (accept) begin
            lock_next = LOCK_IDLE;
        end else if (mem_req) begin
            lock_next = sel_data ? LOCK_DATA : LOCK_INST;
        end else if (lock_state != LOCK_IDLE && !owner_req) begin
            lock_next = LOCK_IDLE;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)                         protocol_err <= 1'b0;
        else if (mem_data_ok && fifo_empty)  protocol_err <= 1'b1;
    end

    id_fifo #(
        .DEPTH (OUTSTANDING),
        .PTR_W (PTR_W)
    ) u_id_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .push    (accept),
        .push_id (owner_id),
        .pop     (pop),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .head    (fifo_head)
    );

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed bench for sram_like_arbiter: inputs change on the falling edge and
// outputs are checked shortly after, before the next rising edge.
module tb_sram_like_arbiter;
    import cpu_bus_pkg::*;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_req, inst_wr, data_req, data_wr;
    logic [1:0]  inst_size, data_size;
    logic [3:0]  inst_wstrb, data_wstrb;
    logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic [31:0] inst_rdata, data_rdata;
    logic        mem_req, mem_wr;
    logic [1:0]  mem_size;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_addr_ok, mem_data_ok;
    logic [31:0] mem_rdata;
    logic        protocol_err;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    sram_like_arbiter #(.OUTSTANDING(4)) dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_wstrb(inst_wstrb), .inst_addr(inst_addr), .inst_wdata(inst_wdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
        .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata), .protocol_err(protocol_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        inst_req = 0; inst_wr = 0; inst_size = SIZE_W; inst_wstrb = 4'h0;
        inst_addr = 32'h0; inst_wdata = 32'h0;
        data_req = 0; data_wr = 0; data_size = SIZE_W; data_wstrb = 4'h0;
        data_addr = 32'h0; data_wdata = 32'h0;
        mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 32'h0;
    endtask

    // Advance to the next falling edge (one rising edge in between), then settle.
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    initial begin
        idle_inputs();
        resetn = 1'b0;
        inst_req = 1; data_req = 1; mem_addr_ok = 1; mem_data_ok = 1;
        #1;
        chk("rst_mem_req",      mem_req,      0);
        chk("rst_inst_addr_ok", inst_addr_ok, 0);
        chk("rst_data_addr_ok", data_addr_ok, 0);
        chk("rst_inst_data_ok", inst_data_ok, 0);
        chk("rst_data_data_ok", data_data_ok, 0);
        idle_inputs();
        tick();
        chk("rst_protocol_err", protocol_err, 0);
        resetn = 1'b1;
        tick();

        // Single fetch, response two cycles later
        inst_req = 1; inst_addr = 32'h1c00_0000; mem_addr_ok = 1;
        #1;
        chk("t1_mem_req",      mem_req,      1);
        chk("t1_mem_addr",     mem_addr,     32'h1c00_0000);
        chk("t1_inst_addr_ok", inst_addr_ok, 1);
        chk("t1_data_addr_ok", data_addr_ok, 0);
        tick();
        inst_req = 0; mem_addr_ok = 0;
        tick();
        mem_data_ok = 1; mem_rdata = 32'h0280_0000;
        #1;
        chk("t1_inst_data_ok", inst_data_ok, 1);
        chk("t1_inst_rdata",   inst_rdata,   32'h0280_0000);
        chk("t1_data_data_ok", data_data_ok, 0);
        tick();
        mem_data_ok = 0;

        // Both requesting: data first, then fetch; responses in that order
        inst_req = 1; inst_addr = 32'h1c00_0004;
        data_req = 1; data_addr = 32'h1000_0040; data_wr = 1; data_wstrb = 4'hf;
        data_wdata = 32'hdead_beef; mem_addr_ok = 1;
        #1;
        chk("t2_mem_addr_a",   mem_addr,     32'h1000_0040);
        chk("t2_mem_wr_a",     mem_wr,       1);
        chk("t2_mem_wdata_a",  mem_wdata,    32'hdead_beef);
        chk("t2_data_addr_ok", data_addr_ok, 1);
        chk("t2_inst_addr_ok", inst_addr_ok, 0);
        tick();
        data_req = 0; data_wr = 0;
        #1;
        chk("t2_mem_addr_b",    mem_addr,     32'h1c00_0004);
        chk("t2_mem_wr_b",      mem_wr,       0);
        chk("t2_inst_addr_ok2", inst_addr_ok, 1);
        tick();
        inst_req = 0; mem_addr_ok = 0;
        mem_data_ok = 1; mem_rdata = 32'haaaa_aaaa;
        #1;
        chk("t2_resp_a_data", data_data_ok, 1);
        chk("t2_resp_a_inst", inst_data_ok, 0);
        tick();
        mem_rdata = 32'hbbbb_bbbb;
        #1;
        chk("t2_resp_b_inst",  inst_data_ok, 1);
        chk("t2_resp_b_data",  data_data_ok, 0);
        chk("t2_resp_b_rdata", data_rdata,   32'hbbbb_bbbb);
        tick();
        mem_data_ok = 0;

        // Stalled fetch keeps the grant while data waits
        inst_req = 1; inst_addr = 32'h1c00_0100; mem_addr_ok = 0;
        #1;
        chk("t3_c1_mem_req",  mem_req,      1);
        chk("t3_c1_mem_addr", mem_addr,     32'h1c00_0100);
        chk("t3_c1_inst_ok",  inst_addr_ok, 0);
        tick();
        data_req = 1; data_addr = 32'h1000_0200;
        #1;
        chk("t3_c2_mem_addr", mem_addr,     32'h1c00_0100);
        chk("t3_c2_data_ok",  data_addr_ok, 0);
        tick();
        chk("t3_c3_mem_addr", mem_addr,     32'h1c00_0100);
        tick();
        mem_addr_ok = 1;
        #1;
        chk("t3_c4_inst_ok",  inst_addr_ok, 1);
        chk("t3_c4_data_ok",  data_addr_ok, 0);
        chk("t3_c4_mem_addr", mem_addr,     32'h1c00_0100);
        tick();
        inst_req = 0;
        #1;
        chk("t3_c5_mem_addr", mem_addr,     32'h1000_0200);
        chk("t3_c5_data_ok",  data_addr_ok, 1);
        tick();
        data_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
        #1;
        chk("t3_resp1_inst", inst_data_ok, 1);
        tick();
        chk("t3_resp2_data", data_data_ok, 1);
        chk("t3_resp2_inst", inst_data_ok, 0);
        tick();
        mem_data_ok = 0;

        // Fill to OUTSTANDING, then check the full stall and its release
        data_req = 1; data_addr = 32'h1000_0300; mem_addr_ok = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("t4_fill%0d", i), data_addr_ok, 1);
            tick();
        end
        chk("t4_full_mem_req", mem_req,      0);
        chk("t4_full_addr_ok", data_addr_ok, 0);
        tick();
        mem_data_ok = 1;
        #1;
        chk("t4_popfull_mem_req", mem_req,      0);
        chk("t4_popfull_addr_ok", data_addr_ok, 0);
        chk("t4_popfull_data_ok", data_data_ok, 1);
        tick();
        mem_data_ok = 0;
        #1;
        chk("t4_resume_mem_req", mem_req,      1);
        chk("t4_resume_addr_ok", data_addr_ok, 1);
        tick();
        data_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("t4_drain%0d", i), data_data_ok, 1);
            tick();
        end
        chk("t4_pre_err", protocol_err, 0);

        // Stray response with nothing outstanding
        #1;
        chk("t5_inst_data_ok", inst_data_ok, 0);
        chk("t5_data_data_ok", data_data_ok, 0);
        tick();
        mem_data_ok = 0;
        chk("t5_err_set", protocol_err, 1);
        tick();
        chk("t5_err_held", protocol_err, 1);

        // Asynchronous reset with two in flight
        inst_req = 1; inst_addr = 32'h1c00_0400; mem_addr_ok = 1;
        #1;
        chk("t6_acc0", inst_addr_ok, 1);
        tick();
        chk("t6_acc1", inst_addr_ok, 1);
        tick();
        #1;
        resetn = 1'b0;
        mem_data_ok = 1;
        #1;
        chk("t6_rst_mem_req",  mem_req,      0);
        chk("t6_rst_addr_ok",  inst_addr_ok, 0);
        chk("t6_rst_data_ok",  inst_data_ok, 0);
        chk("t6_rst_err",      protocol_err, 0);
        idle_inputs();
        tick();
        resetn = 1'b1;
        tick();
        mem_data_ok = 1;
        #1;
        chk("t6_late_inst_ok", inst_data_ok, 0);
        chk("t6_late_data_ok", data_data_ok, 0);
        tick();
        mem_data_ok = 0;
        chk("t6_late_err", protocol_err, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/sram_like_arbiter.md
Name: sram_like_arbiter

Overview:
- Shares one SRAM-like memory port between the instruction-fetch requester (inst_*) and the data requester (data_*, from EX/MEM).
- Sits between the pipeline and the downstream SRAM-like-to-AXI bridge or cache.
- Grants one request per cycle, holds the grant until address handshake completes, and records requester IDs in an in-order FIFO to steer data_ok/rdata back.

Parameters:
- OUTSTANDING, 4, max in-flight accepted-but-unanswered requests; power of two, ≥2
- PTR_W, $clog2(OUTSTANDING), FIFO pointer width (count/pointers use PTR_W+1 bits)

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- inst_req  in  1  fetch request
- inst_wr  in  1  write flag (0 from IF)
- inst_size  in  2  0:byte 1:half 2:word
- inst_wstrb  in  4  byte strobes
- inst_addr  in  32  address
- inst_wdata  in  32  write data
- inst_addr_ok  out  1  fetch request accepted
- inst_data_ok  out  1  fetch response valid
- inst_rdata  out  32  fetch read data
- data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata  in  1/1/2/4/32/32  data-side request, same meaning
- data_addr_ok  out  1  data request accepted
- data_data_ok  out  1  data response valid
- data_rdata  out  32  data read data
- mem_req  out  1  downstream request
- mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata  out  1/2/4/32/32  muxed request fields
- mem_addr_ok  in  1  downstream accept
- mem_data_ok  in  1  downstream response
- mem_rdata  in  32  downstream read data
- protocol_err  out  1  sticky: mem_data_ok arrived with empty FIFO

Behaviour:
- Reset (resetn low, async): FIFO empty, lock clear, protocol_err=0. All *_addr_ok, *_data_ok and mem_req are 0 while in reset.
- Grant (combinational):
  - If lock_valid, owner = lock_owner.
  - Else if data_req, owner = DATA.
  - Else if inst_req, owner = INST.
  - Else no owner.
  - Fixed priority: data over inst.
- mem_req = owner_req & ~fifo_full. mem_wr/size/wstrb/addr/wdata are muxed from the owner; inst side when there is no owner.
- accept = mem_req & mem_addr_ok. owner_addr_ok = accept. The non-owner's addr_ok is 0. Zero-latency pass-through.
- Lock:
  - Set lock_valid=1 and lock_owner=owner when mem_req & ~mem_addr_ok.
  - Clear on accept.
  - Requesters must hold req/fields stable until addr_ok. This guarantees the downstream never sees a request change mid-handshake.
  - If the locked owner drops req (IF cancel violation), clear the lock the next cycle. No push.
- ID FIFO:
  - On accept, push owner ID (0=INST, 1=DATA).
  - On mem_data_ok with non-empty FIFO, pop the head. Route data_ok to the head requester the same cycle.
  - mem_rdata is broadcast to both *_rdata. Responses are strictly in acceptance order.
- Full: mem_req is forced 0 and no addr_ok is given, even if a pop occurs that cycle. The lock is not set while full-stalled.
- Push and pop in the same cycle: count unchanged, both pointers advance, wrap modulo OUTSTANDING.
- mem_data_ok with empty FIFO: no data_ok is asserted, protocol_err sets and stays set until reset.
- Writes occupy FIFO entries like reads. Their data_ok is routed identically.
- Latency: address phase 0 cycles through the arbiter. Response phase 0 cycles (combinational steer from FIFO head).

Decomposition:
- Shared package cpu_bus_pkg:
  - requester ID constants REQ_INST=1'b0, REQ_DATA=1'b1
  - SRAM-like size encodings SIZE_B/H/W
- One sub-module id_fifo: parameterised depth, 1-bit payload, push/pop/full/empty/head, async active-low reset.

Test Plan:
- Only inst_req, addr 0x1c000000, mem_addr_ok=1, mem_data_ok two cycles later with rdata 0x02800000 -> inst_addr_ok same cycle, inst_data_ok=1 and inst_rdata=0x02800000 on that cycle; data_data_ok stays 0.
- inst_req and data_req both high, mem_addr_ok=1 two consecutive cycles -> data accepted first (mem_addr=data_addr), inst second. Responses A,B return data_data_ok then inst_data_ok.
- inst_req alone with mem_addr_ok=0 for 3 cycles, data_req rises in cycle 2 -> mem_addr stays inst_addr (locked) until accept. Data is granted the cycle after.
- Issue 4 accepted requests with no response (OUTSTANDING=4) -> 5th request: mem_req=0, no addr_ok. One mem_data_ok -> the next cycle, mem_req reasserts and the request is accepted.
- mem_data_ok pulse with empty FIFO -> no data_ok on either side, protocol_err=1 and held.
- Assert resetn=0 asynchronously with 2 in flight -> all outputs 0 immediately. After release, the FIFO is empty; a late mem_data_ok raises protocol_err.
